// File: rtl/regfile_pkg.sv
// Shared constants and the multicycle result entry used by the register file,
// the multicycle unit and the write-port scoreboard.
package regfile_pkg;

  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int NREG       = 1 << AW;
  localparam int MC_MAX     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CW         = $clog2(MC_MAX + 1);
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mc_entry_t;

endpackage

// File: rtl/regfile_scoreboard_sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file write-port arbiter (writeback over multicycle FIFO) and
// busy-bit scoreboard stalling decode on hazards against outstanding multicycle writes.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_writes,
  input  logic          id_multi,
  output logic          id_stall,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          mc_valid,
  input  logic [AW-1:0] mc_reg,
  input  logic [DW-1:0] mc_data,
  output logic          mc_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam logic [CW-1:0]  MC_FULL   = CW'(MC_MAX);
  localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   out_cnt;
  mc_entry_t       push_entry;
  mc_entry_t       fifo_head;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_empty;
  logic            hazard;
  logic            cap;
  logic            accept;
  logic            issue;
  logic            set_busy;
  logic            push;
  logic            drain;
  logic            sel_valid;

  assign fifo_empty = (fifo_count == '0);
  assign hazard     = busy[id_rs] || busy[id_rt] || (id_writes && busy[id_rd]);
  assign cap        = id_multi && (out_cnt == MC_FULL);
  assign id_stall   = rst || (id_valid && (hazard || cap));
  assign accept     = id_valid && !id_stall;
  assign issue      = accept && id_multi;
  assign set_busy   = issue && id_writes && (id_rd != '0);

  // Ready looks only at the registered count, never at this cycle's pop.
  assign mc_ready   = !rst && (fifo_count < FIFO_FULL);
  assign push       = mc_valid && mc_ready;
  assign drain      = !rst && !wb_valid && !fifo_empty;
  assign push_entry = '{addr: mc_reg, data: mc_data};

  sync_fifo #(
    .WIDTH ($bits(mc_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (drain),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    sel_valid = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    if (!rst) begin
      if (wb_valid) begin
        sel_valid = 1'b1;
        rf_waddr  = wb_reg;
        rf_wdata  = wb_data;
      end else if (!fifo_empty) begin
        sel_valid = 1'b1;
        rf_waddr  = fifo_head.addr;
        rf_wdata  = fifo_head.data;
      end
    end
    rf_we = sel_valid && (rf_waddr != '0);
  end

  // Set is applied after clear so a same-cycle collision keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (drain)    busy_next[fifo_head.addr] = 1'b0;
    if (set_busy) busy_next[id_rd]          = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      out_cnt <= '0;
    end else begin
      busy <= busy_next;
      case ({issue, drain})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  a_no_orphan_result: assert property (
    @(posedge clk) disable iff (rst) !(mc_valid && (out_cnt == '0) && fifo_empty));

  a_mc_valid_held: assert property (
    @(posedge clk) disable iff (rst) (mc_valid && !mc_ready) |=> mc_valid);

  a_no_set_clear_collision: assert property (
    @(posedge clk) disable iff (rst) !(drain && set_busy && (fifo_head.addr == id_rd)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the scoreboard.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_writes, id_multi;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  bit          busy_m [32];
  int          out_m;
  logic [4:0]  fq_reg [$];
  logic [31:0] fq_dat [$];
  logic [4:0]  pend_q [$];
  bit          mc_taken;

  regfile_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .id_writes (id_writes),
    .id_multi  (id_multi),
    .id_stall  (id_stall),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_reg    (mc_reg),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    out_m = 0;
    fq_reg.delete();
    fq_dat.delete();
    pend_q.delete();
    mc_taken = 1'b0;
  endtask

  // Check outputs of the current cycle, then advance one clock and update the model.
  task automatic cycle();
    bit          es, er, ew, src, drn, acc;
    logic [4:0]  ea;
    logic [31:0] ed;
    #1;
    es = rst || (id_valid && (busy_m[id_rs] || busy_m[id_rt] ||
                              (id_writes && busy_m[id_rd]) || (id_multi && out_m == 4)));
    er = !rst && fq_reg.size() < 2;
    src = 1'b0; ea = '0; ed = '0;
    if (!rst && wb_valid) begin
      src = 1'b1; ea = wb_reg; ed = wb_data;
    end else if (!rst && fq_reg.size() > 0) begin
      src = 1'b1; ea = fq_reg[0]; ed = fq_dat[0];
    end
    ew = src && ea != 0;
    chk("id_stall", 32'(id_stall), 32'(es));
    chk("mc_ready", 32'(mc_ready), 32'(er));
    chk("rf_we", 32'(rf_we), 32'(ew));
    if (rst || ew) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(ea));
      chk("rf_wdata", rf_wdata, ed);
    end
    acc = id_valid && !es;
    drn = !rst && !wb_valid && fq_reg.size() > 0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (drn) begin
        busy_m[fq_reg[0]] = 1'b0;
        void'(fq_reg.pop_front());
        void'(fq_dat.pop_front());
        out_m--;
      end
      mc_taken = mc_valid && er;
      if (mc_taken) begin
        fq_reg.push_back(mc_reg);
        fq_dat.push_back(mc_data);
        void'(pend_q.pop_front());
      end
      if (acc && id_multi) begin
        out_m++;
        if (id_writes && id_rd != 0) busy_m[id_rd] = 1'b1;
        pend_q.push_back(id_writes ? id_rd : 5'd0);
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_writes = 1'b0; id_multi = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic writes, input logic multi);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_writes = writes; id_multi = multi;
  endtask

  task automatic deliver_all();
    int guard;
    guard = 0;
    id_valid = 1'b0;
    while (pend_q.size() > 0 && guard < 50) begin
      mc_valid = 1'b1; mc_reg = pend_q[0]; mc_data = $urandom;
      cycle();
      guard++;
    end
    mc_valid = 1'b0;
    if (pend_q.size() > 0) chk("deliver_timeout", 32'(pend_q.size()), 32'd0);
    repeat (3) cycle();
  endtask

  task automatic drive_random();
    rst       = ($urandom_range(0, 149) == 0);
    id_valid  = $urandom_range(0, 1) == 1;
    id_rs     = 5'($urandom_range(0, 7));
    id_rt     = 5'($urandom_range(0, 7));
    id_rd     = 5'($urandom_range(0, 7));
    id_writes = $urandom_range(0, 3) != 0;
    id_multi  = $urandom_range(0, 2) == 0;
    wb_valid  = $urandom_range(0, 2) == 0;
    wb_reg    = 5'($urandom_range(0, 31));
    wb_data   = $urandom;
    if (rst) begin
      mc_valid = 1'b0;
    end else if (mc_valid && !mc_taken) begin
      mc_valid = 1'b1;
    end else if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      mc_valid = 1'b1; mc_reg = pend_q[0]; mc_data = $urandom;
    end else begin
      mc_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    idle();
    @(posedge clk); #1;

    // Reset: outputs forced even with writeback traffic present
    rst = 1'b1; wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h1234_5678;
    cycle();
    cycle();
    idle();
    #1;
    chk("post_rst_ready", 32'(mc_ready), 32'd1);
    chk("post_rst_stall", 32'(id_stall), 32'd0);
    cycle();

    // RAW stall on a multicycle destination until its result drains
    issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    cycle();
    issue(5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    cycle();
    cycle();
    mc_valid = 1'b1; mc_reg = 5'd5; mc_data = 32'hDEAD_BEEF;
    cycle();
    mc_valid = 1'b0;
    #1;
    chk("raw_drain_we", 32'(rf_we), 32'd1);
    chk("raw_drain_addr", 32'(rf_waddr), 32'd5);
    chk("raw_drain_data", rf_wdata, 32'hDEAD_BEEF);
    chk("raw_drain_stall", 32'(id_stall), 32'd1);
    cycle();
    #1;
    chk("raw_released", 32'(id_stall), 32'd0);
    cycle();
    idle();

    // Writeback priority holds two queued results until it goes quiet
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    cycle();
    issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    cycle();
    idle();
    wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 32'h0000_0020;
    mc_valid = 1'b1; mc_reg = 5'd8; mc_data = 32'h8888_0008;
    cycle();
    mc_reg = 5'd9; mc_data = 32'h9999_0009;
    cycle();
    mc_valid = 1'b0;
    #1;
    chk("wb_full_ready", 32'(mc_ready), 32'd0);
    chk("wb_wins_addr", 32'(rf_waddr), 32'd20);
    cycle();
    wb_valid = 1'b0;
    #1;
    chk("drain_first", 32'(rf_waddr), 32'd8);
    cycle();
    #1;
    chk("drain_second", 32'(rf_waddr), 32'd9);
    cycle();

    // Outstanding cap: fifth multicycle op waits for the first drain
    for (int r = 1; r <= 4; r++) begin
      issue(5'd0, 5'd0, 5'(r), 1'b1, 1'b1);
      cycle();
    end
    issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
    #1;
    chk("cap_stall", 32'(id_stall), 32'd1);
    cycle();
    mc_valid = 1'b1; mc_reg = 5'd1; mc_data = 32'h0000_0001;
    cycle();
    mc_valid = 1'b0;
    cycle();
    #1;
    chk("cap_released", 32'(id_stall), 32'd0);
    cycle();
    deliver_all();

    // Register 0 is never busy and never written
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    cycle();
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle();
    deliver_all();

    // Reset with queued results and a busy register
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    cycle();
    issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b1);
    cycle();
    idle();
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h2;
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'h7777_7777;
    cycle();
    mc_reg = 5'd11; mc_data = 32'hBBBB_BBBB;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    issue(5'd7, 5'd11, 5'd7, 1'b1, 1'b0);
    #1;
    chk("rst_no_stale_we", 32'(rf_we), 32'd0);
    chk("rst_busy_cleared", 32'(id_stall), 32'd0);
    cycle();
    idle();

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
